// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state type and alignment helper for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Size 2'b11 is treated as a word access, matching the bus-side decode.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/RDataGen.sv
// rtl/RDataGen.sv - load data lane extraction with sign extension
module RDataGen
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the bus word and sign-extend it to 32 bits.
  always_comb begin
    byte_sel = rdata[8*offset +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (size)
      SZ_BYTE: data = {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/st_align.sv
// rtl/st_align.sv - store data lane replication and byte strobe generation
module st_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_lane,
  output logic [3:0]  wstrb
);

  // Replicate the LSB-justified data across every lane so the strobes alone select the target bytes.
  always_comb begin
    wdata_lane = wdata;
    wstrb      = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wdata_lane = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata_lane = {2{wdata[15:0]}};
        wstrb      = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_lane = wdata;
        wstrb      = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store controller on a valid/ready memory bus
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state;
  logic          we_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   ld_data;

  st_align u_st_align (
    .size       (req_size),
    .offset     (req_addr[1:0]),
    .wdata      (req_wdata),
    .wdata_lane (st_wdata),
    .wstrb      (st_wstrb)
  );

  RDataGen u_rdata_gen (
    .size   (size_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (ld_data)
  );

  assign req_ready = (state == ST_IDLE);

  // Request/bus/response sequencing; all bus and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      size_q        <= SZ_BYTE;
      off_q         <= 2'b00;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            size_q <= req_size;
            off_q  <= req_addr[1:0];
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= req_we;
              mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata     <= req_we ? st_wdata : 32'h0;
              mem_wstrb     <= req_we ? st_wstrb : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= we_q ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt + 1'b1;
            if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_checks = 0;
  int n_err    = 0;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; mem_req_ready = 1'b1; mem_rvalid = 1'b0;
    mem_rdata = '0; resp_ready = 1'b1;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    tick();

    // Load byte at 0x103; acceptance edge is cycle 1, resp_valid expected in cycle 4.
    issue(1'b0, 2'b00, 32'h103, 32'h0);
    chk("lb_mem_req_valid", mem_req_valid, 1);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_wstrb", mem_wstrb, 4'b0000);
    chk("lb_mem_we", mem_we, 0);
    chk("lb_req_ready_busy", req_ready, 0);
    tick();
    chk("lb_mem_req_drop", mem_req_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80112233;
    tick();
    mem_rvalid = 1'b0;
    chk("lb_lat4_resp_valid", resp_valid, 1);
    chk("lb_resp_data", resp_data, 32'hFFFFFF80);
    chk("lb_resp_err", resp_err, 0);
    tick();
    chk("lb_done_req_ready", req_ready, 1);
    chk("lb_done_resp_valid", resp_valid, 0);

    // Store half at 0x22.
    issue(1'b1, 2'b01, 32'h22, 32'h0000BEEF);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_mem_wstrb", mem_wstrb, 4'b1100);
    chk("sh_mem_addr", mem_addr, 32'h20);
    chk("sh_mem_we", mem_we, 1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("sh_resp_valid", resp_valid, 1);
    chk("sh_resp_data", resp_data, 0);
    chk("sh_resp_err", resp_err, 0);
    tick();

    // Store byte at 0x5.
    issue(1'b1, 2'b00, 32'h5, 32'h000000A5);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_mem_wstrb", mem_wstrb, 4'b0010);
    chk("sb_mem_addr", mem_addr, 32'h4);
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("sb_resp_valid", resp_valid, 1);
    tick();

    // Misaligned word load at 0x6: error response in cycle 2, no bus request.
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 32'h6, 32'h0);
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_resp_err", resp_err, 1);
    chk("mis_resp_data", resp_data, 0);
    chk("mis_no_mem_req", mem_req_valid, 0);
    resp_ready = 1'b1;
    tick();
    chk("mis_no_mem_req2", mem_req_valid, 0);
    chk("mis_req_ready", req_ready, 1);

    // Misaligned half load at 0x11.
    issue(1'b0, 2'b01, 32'h11, 32'h0);
    chk("mish_resp_err", resp_err, 1);
    chk("mish_no_mem_req", mem_req_valid, 0);
    tick();

    // Backpressure on both the bus request and the response.
    mem_req_ready = 1'b0;
    issue(1'b0, 2'b10, 32'h30, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_req_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_addr, 32'h30);
      chk("bp_mem_wstrb", mem_wstrb, 4'b0000);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("bp_mem_req_still", mem_req_valid, 1);
    tick();
    chk("bp_mem_req_drop", mem_req_valid, 0);
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, 32'hCAFE0001);
      chk("bp_resp_err", resp_err, 0);
      chk("bp_req_ready_resp", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_done_resp_valid", resp_valid, 0);
    chk("bp_done_req_ready", req_ready, 1);

    // Timeout: no response for 4 WAIT cycles, then a late response is ignored.
    issue(1'b0, 2'b01, 32'h2, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_no_resp", resp_valid, 0);
      tick();
    end
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_data", resp_data, 0);
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12341234;
    tick();
    mem_rvalid = 1'b0;
    chk("to_late_data", resp_data, 0);
    chk("to_late_err", resp_err, 1);
    resp_ready = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("to_idle_resp_valid", resp_valid, 0);
    chk("to_idle_mem_req", mem_req_valid, 0);
    chk("to_idle_req_ready", req_ready, 1);

    // Reset while in WAIT, then a clean word load.
    issue(1'b0, 2'b10, 32'h44, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_ready", req_ready, 1);
    chk("rw_mem_req_valid", mem_req_valid, 0);
    chk("rw_resp_valid", resp_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_discard_resp", resp_valid, 0);
    issue(1'b0, 2'b10, 32'h40, 32'h0);
    chk("rw_mem_addr", mem_addr, 32'h40);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_resp_valid", resp_valid, 1);
    chk("rw_resp_data", resp_data, 32'h12345678);
    chk("rw_resp_err", resp_err, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
